// File: rtl/gpu_def.sv
// Shared GPU definitions for the rectangle scanner and its span helpers.
// Latency: n/a (types only).
// Backpressure: n/a.
package gpu_def;

  // Scanner job phases: waiting for a command, emitting groups, one-cycle completion.
  typedef enum logic [1:0] {
    SR_IDLE = 2'd0,
    SR_SCAN = 2'd1,
    SR_DONE = 2'd2
  } scanRectState_t;

endpackage

// File: rtl/gpu_scan_span_mask.sv
// Lane mask for one pixel group: lane i is set when gx+i lies in [lo, hi).
// Latency: combinational.
// Backpressure: none; the caller holds the inputs stable while stalled.
module gpu_scan_span_mask #(
  parameter int XW = 14,
  parameter int P  = 2
) (
  input  logic signed [XW-1:0] gx_i,
  input  logic signed [XW-1:0] lo_i,
  input  logic signed [XW-1:0] hi_i,
  output logic [P-1:0]         mask_o
);

  // Operands are wide enough that neither the lane position nor the span end can wrap.
  for (genvar i = 0; i < P; i++) begin : g_lane
    logic signed [XW-1:0] px;
    assign px        = gx_i + $signed(XW'(i));
    assign mask_o[i] = (px >= lo_i) && (px < hi_i);
  end

endmodule

// File: rtl/gpu_scan_rect.sv
// Row-major rectangle scanner emitting aligned PIX_PER_STEP pixel groups with lane masks.
// Latency: first group valid the cycle after an accepted start; one group per handshake, no bubbles.
// Backpressure: valid/ready; a group is held stable until accepted, abort drops it.
module gpu_scan_rect
  import gpu_def::*;
#(
  parameter int COORD_W      = 12,
  parameter int PIX_PER_STEP = 2
) (
  input  logic                    i_clk,
  input  logic                    i_nRst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [COORD_W-1:0]      i_x0,
  input  logic [COORD_W-1:0]      i_y0,
  input  logic [COORD_W-1:0]      i_w,
  input  logic [COORD_W-1:0]      i_h,
  input  logic                    i_interlace,
  input  logic                    i_field,
  output logic                    o_busy,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [COORD_W-1:0]      o_x,
  output logic [COORD_W-1:0]      o_y,
  output logic [PIX_PER_STEP-1:0] o_mask,
  output logic                    o_lastInRow,
  output logic                    o_lastPix,
  output logic                    o_done
);

  localparam int CW1 = COORD_W + 1;  // down-counter width
  localparam int XW  = COORD_W + 2;  // horizontal span arithmetic, never wraps
  localparam int LP  = (PIX_PER_STEP > 1) ? $clog2(PIX_PER_STEP) : 0;
  localparam logic [COORD_W-1:0] PMASK = COORD_W'(PIX_PER_STEP - 1);

  scanRectState_t         state_q, state_d;
  logic signed [XW-1:0]   gx_q, gx_d;      // current group origin (unwrapped)
  logic signed [XW-1:0]   xa_q, xa_d;      // aligned row start
  logic signed [XW-1:0]   lo_q, lo_d;      // x0
  logic signed [XW-1:0]   hi_q, hi_d;      // x0 + w
  logic [COORD_W-1:0]     y_q, y_d;
  logic                   ystep2_q, ystep2_d;
  logic [CW1-1:0]         rows_q, rows_d;  // rows remaining, including current
  logic [CW1-1:0]         cols_q, cols_d;  // groups remaining in current row
  logic [CW1-1:0]         ncols_q, ncols_d;

  logic                   start_ok, off, empty, hs, last_in_row, last_pix;
  logic [CW1-1:0]         h_ext, rows_calc, cols_calc;
  logic signed [XW-1:0]   x0_ext, xa_calc;

  // Job geometry derived from the command inputs; only used on an accepted start.
  always_comb begin
    start_ok  = i_start && !i_abort && (state_q == SR_IDLE);
    off       = i_interlace & (i_y0[0] ^ i_field);
    h_ext     = {1'b0, i_h};
    rows_calc = !i_interlace ? h_ext : (off ? (h_ext >> 1) : ((h_ext + CW1'(1)) >> 1));
    cols_calc = ({1'b0, i_x0 & PMASK} + {1'b0, i_w} + CW1'(PIX_PER_STEP - 1)) >> LP;
    x0_ext    = $signed({{2{i_x0[COORD_W-1]}}, i_x0});
    xa_calc   = $signed({{2{i_x0[COORD_W-1]}}, i_x0 & ~PMASK});
    empty     = (i_w == '0) || (rows_calc == '0);
  end

  assign hs          = (state_q == SR_SCAN) && i_ready;
  assign last_in_row = (cols_q == CW1'(1));
  assign last_pix    = last_in_row && (rows_q == CW1'(1));

  // FSM and row/column walk; abort overrides everything else.
  always_comb begin
    state_d  = state_q;
    gx_d     = gx_q;
    xa_d     = xa_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    y_d      = y_q;
    ystep2_d = ystep2_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    ncols_d  = ncols_q;
    case (state_q)
      SR_IDLE: begin
        if (start_ok) begin
          gx_d     = xa_calc;
          xa_d     = xa_calc;
          lo_d     = x0_ext;
          hi_d     = x0_ext + $signed({2'b00, i_w});
          y_d      = i_y0 + COORD_W'(off);
          ystep2_d = i_interlace;
          rows_d   = rows_calc;
          cols_d   = cols_calc;
          ncols_d  = cols_calc;
          state_d  = empty ? SR_DONE : SR_SCAN;
        end
      end
      SR_SCAN: begin
        if (hs) begin
          if (last_pix) begin
            state_d = SR_DONE;
          end else if (last_in_row) begin
            gx_d   = xa_q;
            y_d    = y_q + (ystep2_q ? COORD_W'(2) : COORD_W'(1));
            rows_d = rows_q - CW1'(1);
            cols_d = ncols_q;
          end else begin
            gx_d   = gx_q + $signed(XW'(PIX_PER_STEP));
            cols_d = cols_q - CW1'(1);
          end
        end
      end
      default: state_d = SR_IDLE;
    endcase
    if (i_abort) state_d = SR_IDLE;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q  <= SR_IDLE;
      gx_q     <= '0;
      xa_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      y_q      <= '0;
      ystep2_q <= 1'b0;
      rows_q   <= '0;
      cols_q   <= '0;
      ncols_q  <= '0;
    end else begin
      state_q  <= state_d;
      gx_q     <= gx_d;
      xa_q     <= xa_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      y_q      <= y_d;
      ystep2_q <= ystep2_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      ncols_q  <= ncols_d;
    end
  end

  gpu_scan_span_mask #(
    .XW(XW),
    .P (PIX_PER_STEP)
  ) u_mask (
    .gx_i  (gx_q),
    .lo_i  (lo_q),
    .hi_i  (hi_q),
    .mask_o(o_mask)
  );

  assign o_valid     = (state_q == SR_SCAN);
  assign o_busy      = (state_q != SR_IDLE);
  assign o_done      = (state_q == SR_DONE);
  assign o_x         = gx_q[COORD_W-1:0];
  assign o_y         = y_q;
  assign o_lastInRow = o_valid && last_in_row;
  assign o_lastPix   = o_valid && last_pix;

endmodule
